mem_store_buffer: RTL and testbench
===================================

// Module: mem_store_buffer
// PURPOSE
//   MEM-stage store formatter and write buffer: the write-side counterpart of the WB-stage load decoder.
//   - Aligns SB/SH/SW data onto the 32-bit data-memory word.
//   - Generates active-low per-byte write enables.
//   - Queues formatted stores in a small FIFO and drains them to DM over a req/ack handshake.
//   - Flags loads that hit a pending store word, so the hazard unit stalls them.
// PARAMETERS
//   DEPTH   4   store-buffer entries; power of two, >= 2
// PORTS
//   clk             in   1   core clock; all state updates on posedge
//   rst             in   1   synchronous, active-high reset
//   st_valid_i      in   1   MEM stage presents a store this cycle
//   st_func_i       in   3   funct3: 000 SB, 001 SH, 010 SW; others illegal
//   st_addr_i       in   32  byte address (ALU result)
//   st_data_i       in   32  rs2 value, unaligned (low bits significant)
//   st_ready_o      out  1   buffer can accept a store (= !full)
//   dm_req_o        out  1   head entry valid, write requested
//   dm_addr_o       out  32  head word address, bits [1:0] = 2'b00
//   dm_wdata_o      out  32  head aligned write data
//   dm_web_o        out  4   head byte write enables, active-low, bit i = byte i
//   dm_ack_i        in   1   DM accepted head this cycle; sampled only while dm_req_o=1
//   ld_addr_i       in   32  address of load currently in MEM
//   ld_hazard_o     out  1   ld_addr_i[31:2] matches a buffered or incoming store word
//   misalign_err_o  out  1   one-cycle pulse: last store dropped (misaligned/illegal)
//   count_o         out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//   Reset (rst=1 at posedge):
//   - rd/wr pointers and count cleared.
//   - Pending entries are discarded, including in-flight requests.
//   - Registered misalign_err_o <= 0.
//   - While empty after reset: dm_req_o=0, dm_addr_o/dm_wdata_o=0, dm_web_o=4'hF, ld_hazard_o=0, count_o=0.
//   Legality:
//   - SB is always legal.
//   - SH is legal iff addr[0]=0.
//   - SW is legal iff addr[1:0]=0.
//   - Any other funct3 is illegal.
//   Accept rule: push iff st_valid_i & st_ready_o & legal.
//   - The entry stores word addr, aligned data, and web.
//   Drop rule: st_valid_i & st_ready_o & !legal.
//   - No push; misalign_err_o=1 on the following cycle only.
//   st_valid_i while full: no push, no error; the pipeline must hold the store and stall.
//   Formatting (b = addr[1:0]):
//   - SB: wdata={4{d[7:0]}}, web=~(4'b0001<<b).
//   - SH: wdata={2{d[15:0]}}, web = b[1] ? 4'b0011 : 4'b1100.
//   - SW: wdata=d, web=4'b0000.
//   Drain:
//   - dm_* outputs are driven from the head entry registers (no combinational path from st_* inputs).
//   - dm_req_o = (count != 0).
//   - Head is popped at posedge when dm_req_o & dm_ack_i.
//   - Head fields stay stable until ack.
//   - dm_ack_i while empty is ignored.
//   Latency: a store accepted at edge N appears on dm_* after edge N (cycle N+1) if the buffer was empty.
//   - No bypass path.
//   Simultaneous push+pop:
//   - Count unchanged; both pointers advance, wrapping modulo DEPTH.
//   - When full, st_ready_o=0 even if the head is being acked this cycle (no same-cycle reuse).
//   Ordering: strict FIFO; stores reach DM in program order.
//   ld_hazard_o (combinational):
//   - OR over all valid entries of (entry.addr[31:2] == ld_addr_i[31:2]).
//   - Also includes the store being accepted this cycle.
//   - An entry being popped this cycle still counts.
//   count_o ranges 0..DEPTH; full = (count==DEPTH).
// TESTING
//   1. SB addr=0x1003 data=0x000000A5 -> dm_addr=0x1000, wdata=0xA5A5A5A5, web=4'b0111, req at cycle N+1.
//   2. SH addr=0x2002 data=0x1234BEEF -> wdata=0xBEEFBEEF, web=4'b0011. SH addr=0x2001 -> no push, misalign_err_o=1 one cycle.
//   3. Fill: push 4 SW with dm_ack_i=0 -> count_o=4, st_ready_o=0. A 5th store is held (not lost, no error). Ack one -> ready returns the next cycle.
//   4. Push+ack every cycle for 10 cycles across pointer wrap -> count constant, DM sees the addresses in issue order.
//   5. SW 0x3000 buffered, ld_addr_i=0x3002 -> ld_hazard_o=1. ld_addr_i=0x3004 -> 0. After ack of 0x3000 -> 0.
//   6. Assert rst with 3 entries pending and dm_req_o=1 -> the next cycle shows count_o=0, dm_req_o=0, web=4'hF, no DM write issued.

Source files
------------

// File: rtl/mem_store_buffer.sv
// MEM-stage store formatter and write buffer: aligns SB/SH/SW data, builds active-low
// byte enables, queues legal stores in a FIFO and drains them to data memory via req/ack.
module mem_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       st_valid_i,
    input  logic [2:0]                 st_func_i,
    input  logic [31:0]                st_addr_i,
    input  logic [31:0]                st_data_i,
    output logic                       st_ready_o,
    output logic                       dm_req_o,
    output logic [31:0]                dm_addr_o,
    output logic [31:0]                dm_wdata_o,
    output logic [3:0]                 dm_web_o,
    input  logic                       dm_ack_i,
    input  logic [31:0]                ld_addr_i,
    output logic                       ld_hazard_o,
    output logic                       misalign_err_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          misalign_err_reg;

    logic [29:0]   addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [3:0]    web_mem  [DEPTH];

    logic          legal;
    logic [31:0]   fmt_data;
    logic [3:0]    fmt_web;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;
    logic [DEPTH-1:0] entry_hit;

    // Byte offset bits of the load address never matter for a word-granular hazard.
    logic unused_ld_bits;
    assign unused_ld_bits = ^ld_addr_i[1:0];

    always_comb begin
        legal    = 1'b0;
        fmt_data = st_data_i;
        fmt_web  = 4'hF;
        case (st_func_i)
            3'b000: begin
                legal    = 1'b1;
                fmt_data = {4{st_data_i[7:0]}};
                fmt_web  = ~(4'b0001 << st_addr_i[1:0]);
            end
            3'b001: begin
                legal    = ~st_addr_i[0];
                fmt_data = {2{st_data_i[15:0]}};
                fmt_web  = st_addr_i[1] ? 4'b0011 : 4'b1100;
            end
            3'b010: begin
                legal    = (st_addr_i[1:0] == 2'b00);
                fmt_data = st_data_i;
                fmt_web  = 4'b0000;
            end
            default: begin
                legal    = 1'b0;
                fmt_data = st_data_i;
                fmt_web  = 4'hF;
            end
        endcase
    end

    // Readiness depends only on current occupancy, so a slot freed by an ack is reusable next cycle.
    assign full       = (count_reg == CW'(DEPTH));
    assign st_ready_o = ~full;
    assign push       = st_valid_i & ~full & legal;
    assign drop       = st_valid_i & ~full & ~legal;
    assign pop        = dm_req_o & dm_ack_i;

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg       <= '0;
            wr_ptr_reg       <= '0;
            count_reg        <= '0;
            misalign_err_reg <= 1'b0;
        end else begin
            rd_ptr_reg       <= rd_ptr_next;
            wr_ptr_reg       <= wr_ptr_next;
            count_reg        <= count_next;
            misalign_err_reg <= drop;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_reg] <= st_addr_i[31:2];
            data_mem[wr_ptr_reg] <= fmt_data;
            web_mem[wr_ptr_reg]  <= fmt_web;
        end
    end

    // Head fields are masked while empty so the bus idles at zero data and all enables off.
    assign dm_req_o       = (count_reg != '0);
    assign dm_addr_o      = dm_req_o ? {addr_mem[rd_ptr_reg], 2'b00} : 32'h0;
    assign dm_wdata_o     = dm_req_o ? data_mem[rd_ptr_reg] : 32'h0;
    assign dm_web_o       = dm_req_o ? web_mem[rd_ptr_reg] : 4'hF;
    assign misalign_err_o = misalign_err_reg;
    assign count_o        = count_reg;

    // An entry is live when its distance from the head is below the occupancy.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            logic [PW-1:0] offset;
            assign offset        = PW'(gi) - rd_ptr_reg;
            assign entry_hit[gi] = (CW'(offset) < count_reg) &&
                                   (addr_mem[gi] == ld_addr_i[31:2]);
        end
    endgenerate

    assign ld_hazard_o = (|entry_hit) | (push & (st_addr_i[31:2] == ld_addr_i[31:2]));

endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed bench for mem_store_buffer: formatting, drop, fill/stall, wrap, hazard and reset.
module tb_mem_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid_i;
    logic [2:0]  st_func_i;
    logic [31:0] st_addr_i;
    logic [31:0] st_data_i;
    logic        st_ready_o;
    logic        dm_req_o;
    logic [31:0] dm_addr_o;
    logic [31:0] dm_wdata_o;
    logic [3:0]  dm_web_o;
    logic        dm_ack_i;
    logic [31:0] ld_addr_i;
    logic        ld_hazard_o;
    logic        misalign_err_o;
    logic [2:0]  count_o;

    int n_pass  = 0;
    int n_total = 0;

    mem_store_buffer #(.DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .st_valid_i     (st_valid_i),
        .st_func_i      (st_func_i),
        .st_addr_i      (st_addr_i),
        .st_data_i      (st_data_i),
        .st_ready_o     (st_ready_o),
        .dm_req_o       (dm_req_o),
        .dm_addr_o      (dm_addr_o),
        .dm_wdata_o     (dm_wdata_o),
        .dm_web_o       (dm_web_o),
        .dm_ack_i       (dm_ack_i),
        .ld_addr_i      (ld_addr_i),
        .ld_hazard_o    (ld_hazard_o),
        .misalign_err_o (misalign_err_o),
        .count_o        (count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_st(input logic v, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        st_valid_i = v;
        st_func_i  = f;
        st_addr_i  = a;
        st_data_i  = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        dm_ack_i   = 1'b0;
        ld_addr_i  = 32'h0;
        drive_st(1'b0, 3'b000, 32'h0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_req", 32'(dm_req_o), 32'd0);
        chk("rst_addr", dm_addr_o, 32'h0);
        chk("rst_wdata", dm_wdata_o, 32'h0);
        chk("rst_web", 32'(dm_web_o), 32'hF);
        chk("rst_hazard", 32'(ld_hazard_o), 32'd0);
        chk("rst_ready", 32'(st_ready_o), 32'd1);
        chk("rst_err", 32'(misalign_err_o), 32'd0);

        // SB at byte 3: nothing visible before the edge, head appears right after it
        drive_st(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5);
        #1;
        chk("sb_nobypass", 32'(dm_req_o), 32'd0);
        tick();
        drive_st(1'b0, 3'b000, 32'h0, 32'h0);
        chk("sb_req", 32'(dm_req_o), 32'd1);
        chk("sb_addr", dm_addr_o, 32'h0000_1000);
        chk("sb_wdata", dm_wdata_o, 32'hA5A5_A5A5);
        chk("sb_web", 32'(dm_web_o), 32'h7);
        chk("sb_count", 32'(count_o), 32'd1);
        dm_ack_i = 1'b1;
        tick();
        dm_ack_i = 1'b0;
        chk("sb_popped", 32'(count_o), 32'd0);

        // SB at byte 1
        drive_st(1'b1, 3'b000, 32'h0000_1001, 32'hFFFF_FF7E);
        tick();
        drive_st(1'b0, 3'b000, 32'h0, 32'h0);
        chk("sb1_wdata", dm_wdata_o, 32'h7E7E_7E7E);
        chk("sb1_web", 32'(dm_web_o), 32'hD);
        dm_ack_i = 1'b1;
        tick();
        dm_ack_i = 1'b0;

        // SH upper half, then misaligned SH dropped while the first is acked
        drive_st(1'b1, 3'b001, 32'h0000_2002, 32'h1234_BEEF);
        tick();
        drive_st(1'b0, 3'b000, 32'h0, 32'h0);
        chk("sh_addr", dm_addr_o, 32'h0000_2000);
        chk("sh_wdata", dm_wdata_o, 32'hBEEF_BEEF);
        chk("sh_web", 32'(dm_web_o), 32'h3);
        chk("sh_err0", 32'(misalign_err_o), 32'd0);
        drive_st(1'b1, 3'b001, 32'h0000_2001, 32'h1234_BEEF);
        dm_ack_i = 1'b1;
        tick();
        drive_st(1'b0, 3'b000, 32'h0, 32'h0);
        dm_ack_i = 1'b0;
        chk("sh_mis_err", 32'(misalign_err_o), 32'd1);
        chk("sh_mis_count", 32'(count_o), 32'd0);
        tick();
        chk("sh_err_pulse", 32'(misalign_err_o), 32'd0);

        // SH lower half and an illegal funct3
        drive_st(1'b1, 3'b001, 32'h0000_2000, 32'h0000_C0DE);
        tick();
        drive_st(1'b1, 3'b011, 32'h0000_2100, 32'h0);
        chk("shlo_web", 32'(dm_web_o), 32'hC);
        chk("shlo_wdata", dm_wdata_o, 32'hC0DE_C0DE);
        dm_ack_i = 1'b1;
        tick();
        drive_st(1'b0, 3'b000, 32'h0, 32'h0);
        dm_ack_i = 1'b0;
        chk("illegal_err", 32'(misalign_err_o), 32'd1);
        chk("illegal_count", 32'(count_o), 32'd0);

        // Fill with four SW while DM stalls
        for (int i = 0; i < 4; i++) begin
            drive_st(1'b1, 3'b010, 32'h0000_4000 + 32'(4 * i), 32'hD000_0000 + 32'(i));
            tick();
        end
        chk("full_count", 32'(count_o), 32'd4);
        chk("full_ready", 32'(st_ready_o), 32'd0);
        chk("full_head", dm_addr_o, 32'h0000_4000);
        chk("full_wdata", dm_wdata_o, 32'hD000_0000);
        drive_st(1'b1, 3'b010, 32'h0000_4010, 32'hD000_0004);
        tick();
        chk("held_count", 32'(count_o), 32'd4);
        chk("held_err", 32'(misalign_err_o), 32'd0);
        dm_ack_i = 1'b1;
        #1;
        chk("ack_ready", 32'(st_ready_o), 32'd0);
        tick();
        dm_ack_i = 1'b0;
        chk("ack_count", 32'(count_o), 32'd3);
        chk("ack_ready_nx", 32'(st_ready_o), 32'd1);
        chk("ack_head", dm_addr_o, 32'h0000_4004);
        tick();
        drive_st(1'b0, 3'b000, 32'h0, 32'h0);
        chk("held_pushed", 32'(count_o), 32'd4);
        for (int i = 1; i < 5; i++) begin
            chk("drain_addr", dm_addr_o, 32'h0000_4000 + 32'(4 * i));
            chk("drain_wdata", dm_wdata_o, 32'hD000_0000 + 32'(i));
            dm_ack_i = 1'b1;
            tick();
        end
        dm_ack_i = 1'b0;
        chk("drain_empty", 32'(count_o), 32'd0);

        // Push and ack every cycle across pointer wrap
        drive_st(1'b1, 3'b010, 32'h0000_5000, 32'h5);
        tick();
        for (int k = 1; k <= 10; k++) begin
            drive_st(1'b1, 3'b010, 32'h0000_5000 + 32'(4 * k), 32'(k));
            dm_ack_i = 1'b1;
            #1;
            chk("wrap_order", dm_addr_o, 32'h0000_5000 + 32'(4 * (k - 1)));
            tick();
            chk("wrap_count", 32'(count_o), 32'd1);
        end
        drive_st(1'b0, 3'b000, 32'h0, 32'h0);
        dm_ack_i = 1'b0;
        #1;
        chk("wrap_last", dm_addr_o, 32'h0000_5028);
        dm_ack_i = 1'b1;
        tick();
        dm_ack_i = 1'b0;

        // Load hazard against buffered, incoming and popping stores
        drive_st(1'b1, 3'b010, 32'h0000_3000, 32'h3);
        tick();
        drive_st(1'b0, 3'b000, 32'h0, 32'h0);
        ld_addr_i = 32'h0000_3002;
        #1;
        chk("haz_hit", 32'(ld_hazard_o), 32'd1);
        ld_addr_i = 32'h0000_3004;
        #1;
        chk("haz_miss", 32'(ld_hazard_o), 32'd0);
        drive_st(1'b1, 3'b010, 32'h0000_3004, 32'h4);
        #1;
        chk("haz_incoming", 32'(ld_hazard_o), 32'd1);
        drive_st(1'b0, 3'b000, 32'h0, 32'h0);
        ld_addr_i = 32'h0000_3000;
        dm_ack_i  = 1'b1;
        #1;
        chk("haz_popping", 32'(ld_hazard_o), 32'd1);
        tick();
        dm_ack_i = 1'b0;
        chk("haz_after_ack", 32'(ld_hazard_o), 32'd0);
        ld_addr_i = 32'h0;

        // Reset with three stores pending
        for (int i = 0; i < 3; i++) begin
            drive_st(1'b1, 3'b010, 32'h0000_6000 + 32'(4 * i), 32'(i));
            tick();
        end
        drive_st(1'b0, 3'b000, 32'h0, 32'h0);
        chk("pre_rst_count", 32'(count_o), 32'd3);
        chk("pre_rst_req", 32'(dm_req_o), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("post_rst_count", 32'(count_o), 32'd0);
        chk("post_rst_req", 32'(dm_req_o), 32'd0);
        chk("post_rst_web", 32'(dm_web_o), 32'hF);
        chk("post_rst_addr", dm_addr_o, 32'h0);
        tick();
        chk("post_rst_idle", 32'(dm_req_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
